o_row_writeback: RTL

//  Downstream of the vector division stage. Accepts one normalised output row (O_VECTOR_T, VEC_LEN elems)
//  per vld_in/rdy_out handshake, buffers rows in a small FIFO and serialises each row into
//  VEC_LEN/BEAT_ELEMS memory write beats with addresses. Runs one job of num_rows rows per start pulse.

---
 rtl/o_row_writeback_if.sv | 33 +++
 rtl/o_row_writeback.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/o_row_writeback_if.sv
// rtl/o_row_writeback_if.sv - row input / write-beat output handshake bundle for o_row_writeback
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 16
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

interface o_row_writeback_if #(
    parameter int VEC_LEN    = `MAX_EMBEDDING_DIM,
    parameter int DATA_WIDTH = `INTEGER_WIDTH,
    parameter int BEAT_ELEMS = 4,
    parameter int ADDR_WIDTH = 16
);
    logic                               vld_in;
    logic                               rdy_out;
    logic [VEC_LEN*DATA_WIDTH-1:0]      vec_in;
    logic                               vld_out;
    logic                               rdy_in;
    logic [ADDR_WIDTH-1:0]              wr_addr;
    logic [BEAT_ELEMS*DATA_WIDTH-1:0]   wr_data;
    logic                               wr_last;

    modport master (
        output vld_in, vec_in, rdy_in,
        input  rdy_out, vld_out, wr_addr, wr_data, wr_last
    );

    modport slave (
        input  vld_in, vec_in, rdy_in,
        output rdy_out, vld_out, wr_addr, wr_data, wr_last
    );
endinterface

// File: rtl/o_row_writeback.sv
// rtl/o_row_writeback.sv - buffers O rows and serialises them into addressed write beats
// Optional WB_PERF_CNT_EN adds stall_cnt / starve_cnt performance counter ports.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 16
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

module o_row_writeback #(
    parameter int VEC_LEN    = `MAX_EMBEDDING_DIM,
    parameter int DATA_WIDTH = `INTEGER_WIDTH,
    parameter int BEAT_ELEMS = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [15:0]             num_rows,
    output logic                    done,
`ifdef WB_PERF_CNT_EN
    output logic [31:0]             stall_cnt,
    output logic [31:0]             starve_cnt,
`endif
    o_row_writeback_if.slave        bus
);
    localparam int BEATS  = VEC_LEN / BEAT_ELEMS;
    localparam int BW     = BEAT_ELEMS * DATA_WIDTH;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef logic [BEATS-1:0][BW-1:0] row_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    row_t                   mem_q [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]            rows_in_q, rows_in_d, row_out_q, row_out_d, num_rows_q, num_rows_d;
    logic [BIDX_W-1:0]      beat_idx_q, beat_idx_d;
    logic [ADDR_WIDTH-1:0]  row_addr_q, row_addr_d;
    logic                   fifo_empty, fifo_full, last_beat, push, beat_acc, pop, start_acc;
    row_t                   head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign last_beat  = (beat_idx_q == BIDX_W'(BEATS - 1));

    assign bus.rdy_out = (state_q == S_RUN) && !fifo_full && (rows_in_q < num_rows_q);
    assign bus.vld_out = (state_q == S_RUN) && !fifo_empty;
    assign bus.wr_addr = bus.vld_out ? row_addr_q + ADDR_WIDTH'(beat_idx_q) : '0;
    assign bus.wr_data = bus.vld_out ? head[beat_idx_q] : '0;
    assign bus.wr_last = bus.vld_out && last_beat;
    assign done        = (state_q == S_DONE);

    assign push     = bus.vld_in && bus.rdy_out;
    assign beat_acc = bus.vld_out && bus.rdy_in;
    assign pop      = beat_acc && last_beat;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rows_in_d  = rows_in_q;
        row_out_d  = row_out_q;
        num_rows_d = num_rows_q;
        beat_idx_d = beat_idx_q;
        row_addr_d = row_addr_q;
        start_acc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    num_rows_d = num_rows;
                    row_addr_d = base_addr;
                    rows_in_d  = '0;
                    row_out_d  = '0;
                    beat_idx_d = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    state_d    = (num_rows == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (push) begin
                    wr_ptr_d  = wr_ptr_q + (PTR_W+1)'(1);
                    rows_in_d = rows_in_q + 16'd1;
                end
                if (beat_acc) begin
                    beat_idx_d = last_beat ? '0 : beat_idx_q + BIDX_W'(1);
                end
                if (pop) begin
                    rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(1);
                    row_out_d  = row_out_q + 16'd1;
                    row_addr_d = row_addr_q + ADDR_WIDTH'(BEATS);
                    if (row_out_q == num_rows_q - 16'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rows_in_q  <= '0;
            row_out_q  <= '0;
            num_rows_q <= '0;
            beat_idx_q <= '0;
            row_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rows_in_q  <= rows_in_d;
            row_out_q  <= row_out_d;
            num_rows_q <= num_rows_d;
            beat_idx_q <= beat_idx_d;
            row_addr_q <= row_addr_d;
        end
    end

    // Row storage needs no reset: every read is qualified by a non-empty FIFO.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.vec_in;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, starve_cnt_q;

    always_ff @(posedge clock) begin
        if (!reset || start_acc) begin
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (bus.vld_out && !bus.rdy_in && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((state_q == S_RUN) && fifo_empty && (starve_cnt_q != 32'hFFFF_FFFF)) begin
                starve_cnt_q <= starve_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign starve_cnt = starve_cnt_q;
`endif
endmodule
